muldiv_unit: RTL

Iterative multiply/divide unit for the MIPS core, sitting directly downstream of the datapath register-file read ports: it consumes the Rs/Rt operand values (ReadData1/ReadData2) on MULT/MULTU/DIV/DIVU and holds the HI/LO result registers read back by MFHI/MFLO. It is a multi-cycle radix-2 shift-add/restoring-divide engine. Its busy output is used by the controller to drop the datapath enable while MFHI/MFLO or a new mul/div is pending.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding, FSM states, counter width.
package muldiv_pkg;

    localparam int DBITS = 32;
    localparam int CNT_W = $clog2(DBITS);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step, or restoring-divide step when MULDIV_DIV_EN is defined.
// Purely combinational; no flow control of its own.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int Dbits = DBITS
) (
`ifdef MULDIV_DIV_EN
    input  logic               is_div_i,
`endif
    input  logic [Dbits-1:0]   opnd_i,
    input  logic [2*Dbits-1:0] acc_i,
    output logic [2*Dbits-1:0] acc_o
);

    // Multiply: acc = {partial product, remaining multiplier bits}; add on LSB, shift right.
    logic [Dbits:0] sum;
    assign sum = {1'b0, acc_i[2*Dbits-1:Dbits]} + (acc_i[0] ? {1'b0, opnd_i} : '0);

`ifdef MULDIV_DIV_EN
    // Divide: acc = {remainder, remaining dividend bits}; shift left, trial-subtract divisor.
    logic [Dbits:0]   rem_sh;
    logic [Dbits-1:0] diff;
    logic             ge;

    assign rem_sh = acc_i[2*Dbits-1:Dbits-1];
    assign ge     = (rem_sh >= {1'b0, opnd_i});
    assign diff   = rem_sh[Dbits-1:0] - opnd_i;

    always_comb begin
        acc_o = {sum, acc_i[Dbits-1:1]};
        if (is_div_i) begin
            acc_o = {(ge ? diff : rem_sh[Dbits-1:0]), acc_i[Dbits-2:0], ge};
        end
    end
`else
    assign acc_o = {sum, acc_i[Dbits-1:1]};
`endif

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: Dbits+1 cycles start->result, busy blocks new work. Divider only with MULDIV_DIV_EN.
// start/mthi/mtlo are honoured only in IDLE; anything arriving while busy is dropped.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [DBITS-1:0] a,
    input  logic [DBITS-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [DBITS-1:0] hi,
    output logic [DBITS-1:0] lo
);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DBITS-1:0]     opnd_q;
    logic [2*DBITS-1:0]   acc_q;
    logic [2*DBITS-1:0]   acc_d;
    logic [DBITS-1:0]     hi_q, lo_q;
    logic                 busy_q, done_q;
    logic                 neg_q_q;

    op_e                  op_v;
    logic                 sgn;
    logic                 start_ok;
    logic [DBITS-1:0]     mag_a, mag_b;
    logic [2*DBITS-1:0]   prod;
    logic [DBITS-1:0]     fix_hi, fix_lo;

    assign op_v  = op_e'(op);
    assign sgn   = op_is_signed(op_v);
    assign mag_a = (sgn && a[DBITS-1]) ? -a : a;
    assign mag_b = (sgn && b[DBITS-1]) ? -b : b;
    assign prod  = neg_q_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
    logic is_div_q, neg_r_q, div0_q;
    logic [DBITS-1:0] quo, rem;

    assign start_ok = start;
    assign quo      = acc_q[DBITS-1:0];
    assign rem      = acc_q[2*DBITS-1:DBITS];

    // Divide-by-zero parks the raw dividend in opnd_q so FIX can return it untouched.
    always_comb begin
        fix_hi = prod[2*DBITS-1:DBITS];
        fix_lo = prod[DBITS-1:0];
        if (is_div_q) begin
            fix_lo = div0_q ? '1 : (neg_q_q ? -quo : quo);
            fix_hi = div0_q ? opnd_q : (neg_r_q ? -rem : rem);
        end
    end

    muldiv_step #(.Dbits(DBITS)) u_step (
        .is_div_i (is_div_q),
        .opnd_i   (opnd_q),
        .acc_i    (acc_q),
        .acc_o    (acc_d)
    );
`else
    assign start_ok = start && !op[1];
    assign fix_hi   = prod[2*DBITS-1:DBITS];
    assign fix_lo   = prod[DBITS-1:0];

    muldiv_step #(.Dbits(DBITS)) u_step (
        .opnd_i (opnd_q),
        .acc_i  (acc_q),
        .acc_o  (acc_d)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        neg_q_q <= sgn && (a[DBITS-1] ^ b[DBITS-1]);
`ifdef MULDIV_DIV_EN
                        is_div_q <= op[1];
                        neg_r_q  <= sgn && a[DBITS-1];
                        div0_q   <= (b == '0);
                        if (op[1]) begin
                            acc_q  <= {{DBITS{1'b0}}, mag_a};
                            opnd_q <= (b == '0) ? a : mag_b;
                        end else begin
                            acc_q  <= {{DBITS{1'b0}}, mag_b};
                            opnd_q <= mag_a;
                        end
`else
                        acc_q  <= {{DBITS{1'b0}}, mag_b};
                        opnd_q <= mag_a;
`endif
                    end else begin
                        if (mthi) hi_q <= a;
                        if (mtlo) lo_q <= a;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DBITS - 1)) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
